// File: rtl/caches_types_pkg.sv
// Types private to the cache subsystem, including the memory arbiter FSM state.
package caches_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DGRANT = 2'b01,
        IGRANT = 2'b10
    } arb_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU: the machine word and the RAM handshake state
// reported back to the memory arbiter.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter with synchronous clear (priority over enable) and
// wrap back to 1 once rollover_val has been reached; async active-high reset.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = NUM_CNT_BITS'(1'b0);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1'b1);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Next count: clear, wrap at rollover_val, or increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_ZERO;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = CNT_ONE;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache normally wins, but
// icache is forced through after STARVE_LIMIT back-to-back dcache grants.
module mem_arbiter
    import cpu_types_pkg::*;
    import caches_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam int unsigned        CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_full;
    logic             cnt_clear;
    logic             cnt_up;
    logic             d_req;

    assign d_req       = dREN | dWEN;
    assign starve_full = (starve_cnt == LIMIT);

    // Loads are unqualified copies of the RAM bus; the wait lines qualify them.
    assign iload = ramload;
    assign dload = ramload;
    assign err   = err_q;

    // Arbitration, completion/withdrawal exits, and starve-counter control.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_up    = 1'b0;
        case (state_q)
            IDLE: begin
                if (starve_full && iREN) begin
                    state_d = IGRANT;
                end else if (d_req) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end else begin
                    state_d = IDLE;
                end
                cnt_clear = (state_d == IGRANT) | ~iREN;
                cnt_up    = (state_d == DGRANT) & iREN & ~starve_full;
            end
            DGRANT: begin
                if (!d_req || (ramstate == ACCESS)) begin
                    state_d = IDLE;
                end else begin
                    state_d = DGRANT;
                end
            end
            IGRANT: begin
                if (!iREN || (ramstate == ACCESS)) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port muxing, wait generation and sticky error capture.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = WORD_ZERO;
        ramstore = WORD_ZERO;
        err_d    = err_q;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_req && (ramstate == ACCESS)) begin
                    dwait = 1'b0;
                end else begin
                    dwait = 1'b1;
                end
                if (ramstate == ERROR) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && (ramstate == ACCESS)) begin
                    iwait = 1'b0;
                end else begin
                    iwait = 1'b1;
                end
                if (ramstate == ERROR) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                ramaddr = WORD_ZERO;
            end
        endcase
    end

    // FSM state and error flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_starve_cnt (
        .clk          (CLK),
        .rst          (RST),
        .clear        (cnt_clear),
        .count_enable (cnt_up),
        .rollover_val (LIMIT),
        .count_out    (starve_cnt)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations checked with
// immediate assertions cycle by cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    int vectors;
    int miscompares;

    mem_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST      = 1'b1;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        ramload  = 32'h0;
        ramstate = FREE;

        // Reset state
        #2;
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Both request from IDLE: dcache first, then icache
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h1111_1111;
        #1;
        check("a_idle_dwait", dwait, 1);
        check("a_idle_ramREN", ramREN, 0);
        tick(); #1;
        check("a_d_addr", ramaddr, 32'h100);
        check("a_d_ramREN", ramREN, 1);
        check("a_d_dwait", dwait, 0);
        check("a_d_iwait", iwait, 1);
        check("a_d_dload", dload, 32'h1111_1111);
        tick();
        dREN = 1'b0; #1;
        check("a_idle2_iwait", iwait, 1);
        check("a_idle2_ramREN", ramREN, 0);
        tick();
        ramload = 32'h2222_2222; #1;
        check("a_i_addr", ramaddr, 32'h200);
        check("a_i_ramREN", ramREN, 1);
        check("a_i_iwait", iwait, 0);
        check("a_i_iload", iload, 32'h2222_2222);
        check("a_i_dwait", dwait, 1);
        tick();
        iREN = 1'b0; ramstate = FREE; #1;
        check("a_end_iwait", iwait, 1);

        // Starvation: four dcache words, then icache forced through
        dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h400; ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check($sformatf("b_d%0d_dwait", k), dwait, 0);
            check($sformatf("b_d%0d_iwait", k), iwait, 1);
            tick(); #1;
            check($sformatf("b_idle%0d_dwait", k), dwait, 1);
        end
        tick(); #1;
        check("b_i_iwait", iwait, 0);
        check("b_i_dwait", dwait, 1);
        check("b_i_addr", ramaddr, 32'h400);
        tick(); #1;
        check("b_idle_ramREN", ramREN, 0);
        tick(); #1;
        check("b_cleared_dwait", dwait, 0);
        check("b_cleared_addr", ramaddr, 32'h300);
        // Withdrawal during grant: strobes drop, no wait pulse
        dREN = 1'b0; iREN = 1'b0; #1;
        check("b_wd_ramREN", ramREN, 0);
        check("b_wd_dwait", dwait, 1);
        tick(); #1;
        check("b_wd_idle_ramREN", ramREN, 0);
        check("b_wd_idle_dwait", dwait, 1);

        // Write with dREN also high: dWEN wins, 3 BUSY then ACCESS
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h3100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) ramstate = ACCESS;
            #1;
            check($sformatf("c_w%0d_ramWEN", k), ramWEN, 1);
            check($sformatf("c_w%0d_ramREN", k), ramREN, 0);
            check($sformatf("c_w%0d_addr", k), ramaddr, 32'h3100);
            check($sformatf("c_w%0d_store", k), ramstore, 32'hDEAD_BEEF);
            check($sformatf("c_w%0d_dwait", k), dwait, (k == 3) ? 32'd0 : 32'd1);
            check($sformatf("c_w%0d_iwait", k), iwait, 1);
        end
        tick();
        dWEN = 1'b0; dREN = 1'b0; ramstate = FREE; #1;
        check("c_end_dwait", dwait, 1);
        check("c_end_ramWEN", ramWEN, 0);
        check("c_end_store", ramstore, 32'h0);

        // RAM error twice in IGRANT, then ACCESS
        iREN = 1'b1; iaddr = 32'h500; ramstate = ERROR; #1;
        check("d_idle_err", err, 0);
        tick(); #1;
        check("d_e1_iwait", iwait, 1);
        check("d_e1_ramREN", ramREN, 1);
        check("d_e1_err", err, 0);
        tick(); #1;
        check("d_e2_iwait", iwait, 1);
        check("d_e2_addr", ramaddr, 32'h500);
        check("d_e2_err", err, 1);
        tick();
        ramstate = ACCESS; #1;
        check("d_acc_iwait", iwait, 0);
        check("d_acc_err", err, 1);
        tick();
        iREN = 1'b0; ramstate = FREE; #1;
        check("d_after_iwait", iwait, 1);
        check("d_after_err", err, 1);
        tick(); #1;
        check("d_after2_err", err, 1);

        // Reset mid-DGRANT while BUSY
        dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
        tick(); #1;
        check("e_grant_ramREN", ramREN, 1);
        check("e_grant_dwait", dwait, 1);
        check("e_grant_err", err, 1);
        RST = 1'b1; #1;
        check("e_rst_ramREN", ramREN, 0);
        check("e_rst_ramWEN", ramWEN, 0);
        check("e_rst_dwait", dwait, 1);
        check("e_rst_err", err, 0);
        dREN = 1'b0; iREN = 1'b1; iaddr = 32'h700; ramstate = ACCESS; #1;
        check("e_rst_iwait", iwait, 1);
        tick();
        RST = 1'b0; #1;
        check("e_rel_ramREN", ramREN, 0);
        tick(); #1;
        check("e_i_iwait", iwait, 0);
        check("e_i_addr", ramaddr, 32'h700);
        check("e_i_ramREN", ramREN, 1);
        check("e_i_dwait", dwait, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
